// File: rtl/motor_pkg.sv
// Shared definitions for the H-bridge motor sequencer and PWM blocks.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package motor_pkg;

    // H-bridge direction pin encodings {in_a, in_b}
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b10;
    localparam logic [1:0] DIR_REV  = 2'b01;

    // Run-speed duty and ramp step on the 1024-count PWM scale
    localparam int DEFAULT_TARGET_DUTY = 600;
    localparam int DEFAULT_STEP        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_DEAD
    } state_t;

    // Game-side command after gating: disabled or illegal 11 both mean stop
    function automatic logic [1:0] effective_cmd(input logic enable, input logic [1:0] cmd_dir);
        return (enable && (cmd_dir != 2'b11)) ? cmd_dir : DIR_STOP;
    endfunction

endpackage

// File: rtl/motor_tick_div.sv
// Clearable cycle divider: 1-cycle tick pulse every PERIOD enabled cycles.
// Latency: tick is combinational from the count; first tick PERIOD-1 enabled cycles after clear.
// Backpressure: none; clr overrides en and suppresses the tick.
// Ports: clk, rst (async high), clr (sync clear to 0), en (count enable), tick (pulse out).
module motor_tick_div #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// One H-bridge channel sequencer: soft-start/stop duty ramp, dead-time on reversal, estop.
// Latency: every output registered, responds one cycle after the causing input.
// Backpressure: none; level command sampled every cycle, estop overrides everything.
// Ports: clk, rst (async high), enable, cmd_dir[1:0], estop -> in_ab[1:0], duty, at_speed, busy.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int DUTY_W      = 10,
    parameter int TARGET_DUTY = DEFAULT_TARGET_DUTY,
    parameter int STEP        = DEFAULT_STEP,
    parameter int STEP_CYCLES = 100000,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        cmd_dir,
    input  logic              estop,
    output logic [1:0]        in_ab,
    output logic [DUTY_W-1:0] duty,
    output logic              at_speed,
    output logic              busy
);

    // One extra bit so duty+STEP can be compared against the target without wrapping
    localparam logic [DUTY_W:0] STEP_X   = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] TARGET_X = (DUTY_W + 1)'(TARGET_DUTY);

    state_t          state;
    logic [1:0]      cur_dir;
    logic [1:0]      cmd;
    logic [DUTY_W:0] duty_x;
    logic [DUTY_W:0] up_sum;
    logic [DUTY_W:0] dn_diff;
    logic            ramp_en, ramp_clr, ramp_tick;
    logic            dead_en, dead_clr, dead_tick;

    assign cmd     = effective_cmd(enable, cmd_dir);
    assign duty_x  = {1'b0, duty};
    assign up_sum  = duty_x + STEP_X;
    assign dn_diff = duty_x - STEP_X;

    // Ramp tick restarts from zero whenever the ramp direction flips or a ramp is entered
    assign ramp_en  = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
    assign ramp_clr = estop || !ramp_en
                   || ((state == ST_RAMP_UP)   && (cmd != cur_dir))
                   || ((state == ST_RAMP_DOWN) && (cmd == cur_dir));

    assign dead_en  = (state == ST_DEAD);
    assign dead_clr = estop || !dead_en;

    motor_tick_div #(.PERIOD(STEP_CYCLES)) u_ramp_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (ramp_clr),
        .en   (ramp_en),
        .tick (ramp_tick)
    );

    motor_tick_div #(.PERIOD(DEAD_CYCLES)) u_dead_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (dead_clr),
        .en   (dead_en),
        .tick (dead_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_dir  <= DIR_STOP;
            in_ab    <= DIR_STOP;
            duty     <= '0;
            at_speed <= 1'b0;
            busy     <= 1'b0;
        end else if (estop) begin
            state    <= ST_DEAD;
            in_ab    <= DIR_STOP;
            duty     <= '0;
            at_speed <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ab <= DIR_STOP;
                    duty  <= '0;
                    if (cmd != DIR_STOP) begin
                        cur_dir <= cmd;
                        in_ab   <= cmd;
                        state   <= ST_RAMP_UP;
                        busy    <= 1'b1;
                    end
                end
                ST_RAMP_UP: begin
                    if (cmd != cur_dir) begin
                        state <= ST_RAMP_DOWN;
                    end else if (ramp_tick) begin
                        if (up_sum >= TARGET_X) begin
                            duty     <= TARGET_X[DUTY_W-1:0];
                            state    <= ST_RUN;
                            at_speed <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            duty <= up_sum[DUTY_W-1:0];
                        end
                    end
                end
                ST_RUN: begin
                    if (cmd != cur_dir) begin
                        state    <= ST_RAMP_DOWN;
                        at_speed <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (cmd == cur_dir) begin
                        state <= ST_RAMP_UP;
                    end else if (ramp_tick) begin
                        if (duty_x > STEP_X) begin
                            duty <= dn_diff[DUTY_W-1:0];
                        end else begin
                            // Bridge opens on the same edge duty hits zero
                            duty  <= '0;
                            in_ab <= DIR_STOP;
                            state <= ST_DEAD;
                        end
                    end
                end
                ST_DEAD: begin
                    // Command changes are only looked at once the dead-time expires
                    if (dead_tick) begin
                        if (cmd == DIR_STOP) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cur_dir <= cmd;
                            in_ab   <= cmd;
                            state   <= ST_RAMP_UP;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ab    <= DIR_STOP;
                    duty     <= '0;
                    at_speed <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: two instances (target 300 and 250) share stimulus;
// a phase/elapsed-time model predicts every output each cycle, and directed
// literal checks pin the expected ramp, dead-time and reset values.
module tb_motor_ramp_ctrl;

    localparam int SC   = 4;
    localparam int DC   = 5;
    localparam int STEP = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] cmd_dir = 2'b00;
    logic       estop = 1'b0;

    logic [1:0] in_ab_a, in_ab_b;
    logic [9:0] duty_a, duty_b;
    logic       at_speed_a, at_speed_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    motor_ramp_ctrl #(.DUTY_W(10), .TARGET_DUTY(300), .STEP(STEP),
                      .STEP_CYCLES(SC), .DEAD_CYCLES(DC)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .cmd_dir(cmd_dir), .estop(estop),
        .in_ab(in_ab_a), .duty(duty_a), .at_speed(at_speed_a), .busy(busy_a));

    motor_ramp_ctrl #(.DUTY_W(10), .TARGET_DUTY(250), .STEP(STEP),
                      .STEP_CYCLES(SC), .DEAD_CYCLES(DC)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .cmd_dir(cmd_dir), .estop(estop),
        .in_ab(in_ab_b), .duty(duty_b), .at_speed(at_speed_b), .busy(busy_b));

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3, M_DEAD = 4;
    int tgt[2]    = '{300, 250};
    int m_mode[2] = '{M_IDLE, M_IDLE};
    int m_duty[2] = '{0, 0};
    int m_dir[2]  = '{0, 0};
    int m_el[2]   = '{0, 0};   // cycles spent in the current phase since last event
    int eff;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int c, input bit e);
        if (e) begin
            m_mode[i] = M_DEAD; m_duty[i] = 0; m_el[i] = 0;
            return;
        end
        case (m_mode[i])
            M_IDLE: if (c != 0) begin m_dir[i] = c; m_mode[i] = M_UP; m_el[i] = 0; end
            M_UP: begin
                if (c != m_dir[i]) begin
                    m_mode[i] = M_DOWN; m_el[i] = 0;
                end else begin
                    m_el[i]++;
                    if (m_el[i] == SC) begin
                        m_el[i] = 0;
                        m_duty[i] = (m_duty[i] + STEP < tgt[i]) ? m_duty[i] + STEP : tgt[i];
                        if (m_duty[i] == tgt[i]) m_mode[i] = M_RUN;
                    end
                end
            end
            M_RUN: if (c != m_dir[i]) begin m_mode[i] = M_DOWN; m_el[i] = 0; end
            M_DOWN: begin
                if (c == m_dir[i]) begin
                    m_mode[i] = M_UP; m_el[i] = 0;
                end else begin
                    m_el[i]++;
                    if (m_el[i] == SC) begin
                        m_el[i] = 0;
                        m_duty[i] = (m_duty[i] > STEP) ? m_duty[i] - STEP : 0;
                        if (m_duty[i] == 0) m_mode[i] = M_DEAD;
                    end
                end
            end
            default: begin
                m_el[i]++;
                if (m_el[i] == DC) begin
                    m_el[i] = 0;
                    if (c == 0) m_mode[i] = M_IDLE;
                    else begin m_dir[i] = c; m_mode[i] = M_UP; end
                end
            end
        endcase
    endtask

    task automatic compare(input int i, input logic [1:0] ab, input logic [9:0] d,
                           input logic sp, input logic bz);
        int exp_ab;
        string tag;
        tag = (i == 0) ? "A" : "B";
        exp_ab = (m_mode[i] == M_UP || m_mode[i] == M_RUN || m_mode[i] == M_DOWN) ? m_dir[i] : 0;
        check({"cyc_", tag, "_in_ab"}, int'(ab), exp_ab);
        check({"cyc_", tag, "_duty"}, int'(d), m_duty[i]);
        check({"cyc_", tag, "_at_speed"}, int'(sp), int'(m_mode[i] == M_RUN));
        check({"cyc_", tag, "_busy"}, int'(bz),
              int'(m_mode[i] == M_UP || m_mode[i] == M_DOWN || m_mode[i] == M_DEAD));
    endtask

    always @(posedge clk) begin
        eff = (enable && cmd_dir != 2'b11) ? int'(cmd_dir) : 0;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = M_IDLE; m_duty[i] = 0; m_dir[i] = 0; m_el[i] = 0;
            end else begin
                model_step(i, eff, estop);
            end
        end
        #1;
        compare(0, in_ab_a, duty_a, at_speed_a, busy_a);
        compare(1, in_ab_b, duty_b, at_speed_b, busy_b);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(2);
        check("rst_in_ab", int'(in_ab_a), 0);
        check("rst_busy", int'(busy_a), 0);
        rst = 1'b0;
        cyc(1);

        // forward soft start from IDLE
        enable = 1'b1; cmd_dir = 2'b10;
        cyc(1);
        check("fwd_in_ab", int'(in_ab_a), 2);
        check("fwd_duty0", int'(duty_a), 0);
        check("fwd_busy", int'(busy_a), 1);
        cyc(3);  check("fwd_hold0", int'(duty_a), 0);
        cyc(1);  check("fwd_100", int'(duty_a), 100);
                 check("b_100", int'(duty_b), 100);
        cyc(4);  check("fwd_200", int'(duty_a), 200);
        cyc(4);  check("fwd_300", int'(duty_a), 300);
                 check("fwd_at_speed", int'(at_speed_a), 1);
                 check("b_250_partial", int'(duty_b), 250);
                 check("b_at_speed", int'(at_speed_b), 1);
        cyc(3);  check("run_hold", int'(duty_a), 300);

        // reversal through ramp-down and dead-time
        cmd_dir = 2'b01;
        cyc(1);  check("rev_start_duty", int'(duty_a), 300);
                 check("rev_start_at_speed", int'(at_speed_a), 0);
        cyc(4);  check("rev_200", int'(duty_a), 200);
        cyc(4);  check("rev_100", int'(duty_a), 100);
        cyc(4);  check("rev_0", int'(duty_a), 0);
                 check("rev_dead_in_ab", int'(in_ab_a), 0);
        cyc(4);  check("rev_dead_hold", int'(in_ab_a), 0);
        cyc(1);  check("rev_in_ab", int'(in_ab_a), 1);
        cyc(4);  check("rev_up100", int'(duty_a), 100);
        cyc(8);  check("rev_up300", int'(duty_a), 300);

        // estop in RUN, with a new direction waiting
        cmd_dir = 2'b10; estop = 1'b1;
        cyc(1);  check("estop_duty", int'(duty_a), 0);
                 check("estop_in_ab", int'(in_ab_a), 0);
        estop = 1'b0;
        cyc(4);  check("estop_dead", int'(in_ab_a), 0);
        cyc(1);  check("estop_exit_in_ab", int'(in_ab_a), 2);
        cyc(4);  check("estop_up100", int'(duty_a), 100);
        cyc(8);  check("estop_run", int'(at_speed_a), 1);

        // enable drop then resume mid ramp-down
        enable = 1'b0;
        cyc(1);  check("dis_down_start", int'(duty_a), 300);
        cyc(4);  check("dis_200", int'(duty_a), 200);
        enable = 1'b1;
        cyc(1);  check("resume_duty", int'(duty_a), 200);
                 check("resume_in_ab", int'(in_ab_a), 2);
        cyc(4);  check("resume_300", int'(duty_a), 300);
        enable = 1'b0;
        cyc(13); check("dis_0", int'(duty_a), 0);
                 check("dis_dead_busy", int'(busy_a), 1);
        cyc(5);  check("dis_idle_busy", int'(busy_a), 0);

        // 11 is stop
        enable = 1'b1; cmd_dir = 2'b11;
        cyc(3);  check("cmd11_in_ab", int'(in_ab_a), 0);

        // async reset mid RAMP_UP
        cmd_dir = 2'b10;
        cyc(6);  check("pre_rst_duty", int'(duty_a), 100);
        rst = 1'b1;
        #1;
        check("arst_in_ab", int'(in_ab_a), 0);
        check("arst_duty", int'(duty_a), 0);
        check("arst_at_speed", int'(at_speed_a), 0);
        check("arst_busy", int'(busy_a), 0);
        cyc(1);
        rst = 1'b0; cmd_dir = 2'b00;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
